// File: rtl/ram_stream_reader_pkg.sv
// rtl/ram_stream_reader_pkg.sv - shared FSM encoding and buffer depth for ram_stream_reader
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/ram_stream_reader_skid_buf.sv
// rtl/ram_stream_reader_skid_buf.sv - rd_skid_buf, 2-entry {last, data} FIFO absorbing RAM read latency
module rd_skid_buf
  import ram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last
);

  logic [DATA_WIDTH:0] mem [BUF_DEPTH];
  logic                wr_ptr;
  logic                rd_ptr;
  logic                do_pop;

  // A pop on an empty buffer is ignored so the pointers can never skew.
  assign do_pop = pop && (count != 2'd0);

  // Entry storage, pointers and occupancy; entries are zeroed on clear so the head reads 0 when empty.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_last, push_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr][DATA_WIDTH-1:0];
  assign head_last = mem[rd_ptr][DATA_WIDTH];

endmodule

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - burst RAM read controller to valid/ready stream, abort input under RAM_STREAM_READER_ABORT_EN
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef RAM_STREAM_READER_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  inflight;
  logic                  inflight_last;
  logic [1:0]            buf_count;
  logic [2:0]            occupancy;
  logic                  pop;
  logic                  issue;
  logic                  accept;
  logic                  last_word;
  logic                  abort_hit;
  logic                  push;

`ifdef RAM_STREAM_READER_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign accept    = cmd_valid && (state == IDLE);
  assign pop       = m_valid && m_ready;
  assign last_word = (remaining == LEN_WIDTH'(1));

  // Words already owned by the buffer: stored entries plus the read still in the RAM pipeline.
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight};

  // A read may only be launched if its data is guaranteed a free slot when it lands.
  assign issue = (state == RUN) && (remaining != '0) && !abort_hit &&
                 (occupancy < 3'(BUF_DEPTH) + {2'b00, pop});

  // A landing read is dropped on abort so no word of the truncated burst survives.
  assign push = inflight && !abort_hit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: a zero-length command is consumed without leaving IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept && (cmd_len != '0)) next_state = RUN;
      end
      RUN: begin
        if (abort_hit)                next_state = IDLE;
        else if (issue && last_word)  next_state = DRAIN;
      end
      DRAIN: begin
        if (abort_hit)                next_state = IDLE;
        else if (pop && m_last)       next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    ram_en    = issue;
    ram_addr  = rd_addr;
  end

  // Burst address/length tracking and the one-cycle RAM read pipeline flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr       <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && last_word;
      if (accept) begin
        rd_addr   <= cmd_addr;
        remaining <= cmd_len;
      end else if (issue) begin
        rd_addr   <= rd_addr + ADDR_WIDTH'(1);
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

  rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (abort_hit),
    .push      (push),
    .push_data (ram_dout),
    .push_last (inflight_last),
    .pop       (pop),
    .count     (buf_count),
    .head_data (m_data),
    .head_last (m_last)
  );

  assign m_valid = (buf_count != 2'd0);

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - scoreboard bench for ram_stream_reader with a behavioural RAM
module tb_ram_stream_reader;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 11;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          abort = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;

  logic [DW-1:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int issued = 0;
  int popped = 0;
  int burst_pops = 0;
  int last_seen = 0;
  int valid_seen = 0;
  int en_seen = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;

  logic [AW-1:0] exp_addr [$];
  logic [DW:0]   exp_word [$];
  logic [AW-1:0] mon_a;
  logic [DW:0]   mon_w;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  ram_stream_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef RAM_STREAM_READER_ABORT_EN
    .abort     (abort),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Simple dual-port RAM read port: registered output, updated only when enabled.
  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  // Output monitor: address and word scoreboards, credit, stall-hold and buffer-bound checks.
  always @(negedge clk) begin
    if (rst || abort) begin
      issued = 0;
      popped = 0;
      prev_stall = 1'b0;
    end else begin
      if (ram_en) begin
        en_seen++;
        checks++;
        if (exp_addr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue got addr=%h required none", ram_addr);
        end else begin
          mon_a = exp_addr.pop_front();
          if (ram_addr !== mon_a) begin
            errors++;
            $display("FAIL ram_addr got=%h required=%h", ram_addr, mon_a);
          end
        end
        checks++;
        if ((issued - popped - ((m_valid && m_ready) ? 1 : 0)) >= 2) begin
          errors++;
          $display("FAIL credit ram_en=1 with occupancy=%0d pop=%0d", issued - popped, m_valid && m_ready);
        end
      end
      checks++;
      if (dut.u_buf.count > 2'd2) begin
        errors++;
        $display("FAIL buf_count got=%0d required<=2", dut.u_buf.count);
      end
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold got v=%b d=%h l=%b required v=1 d=%h l=%b",
                   m_valid, m_data, m_last, prev_data, prev_last);
        end
      end
      if (m_valid) valid_seen++;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_word.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word got=%h required none", m_data);
        end else begin
          mon_w = exp_word.pop_front();
          if ({m_last, m_data} !== mon_w) begin
            errors++;
            $display("FAIL word got last=%b data=%h required last=%b data=%h",
                     m_last, m_data, mon_w[DW], mon_w[DW-1:0]);
          end
        end
        if (burst_pops == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        burst_pops++;
        if (m_last) last_seen++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (ram_en) issued++;
      if (m_valid && m_ready) popped++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] n);
    logic [AW-1:0] ai;
    for (int i = 0; i < int'(n); i++) begin
      ai = a + AW'(i);
      exp_addr.push_back(ai);
      exp_word.push_back({(i == int'(n) - 1), mem[ai]});
    end
    burst_pops = 0;
    last_seen  = 0;
    valid_seen = 0;
    cmd_valid  = 1'b1;
    cmd_addr   = a;
    cmd_len    = n;
    tick();
    accept_cyc = cyc;
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit ok, output int fall_cyc);
    ok = 1'b0;
    fall_cyc = 0;
    for (int i = 0; i < bound; i++) begin
      if (!busy) begin
        ok = 1'b1;
        fall_cyc = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({cmd_ready, ram_en, ram_addr, m_valid, m_data, m_last, busy} !== {1'b1, 1'b0, 10'd0, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b en=%b addr=%h v=%b d=%h l=%b busy=%b required 1 0 000 0 0 0 0",
               cmd_ready, ram_en, ram_addr, m_valid, m_data, m_last, busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_burst();
    bit ok;
    int fall;
    m_ready = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL single_cmd_ready got=%b required=1", cmd_ready); end
    send_cmd(10'h010, 11'd4);
    wait_idle(50, ok, fall);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout got busy=1 required busy=0"); end
    checks++;
    if (burst_pops != 4 || last_seen != 1) begin
      errors++;
      $display("FAIL single_count got pops=%0d lasts=%0d required 4 1", burst_pops, last_seen);
    end
    checks++;
    if (last_pop_cyc - first_pop_cyc != 3) begin
      errors++;
      $display("FAIL single_consecutive got span=%0d required=3", last_pop_cyc - first_pop_cyc);
    end
    checks++;
    if (first_pop_cyc - accept_cyc != 2) begin
      errors++;
      $display("FAIL single_latency got=%0d required=2", first_pop_cyc - accept_cyc);
    end
    checks++;
    if (fall != last_pop_cyc + 1) begin
      errors++;
      $display("FAIL single_busy_fall got=%0d required=%0d", fall, last_pop_cyc + 1);
    end
    checks++;
    if (exp_word.size() != 0 || exp_addr.size() != 0) begin
      errors++;
      $display("FAIL single_leftover got words=%0d addrs=%0d required 0 0", exp_word.size(), exp_addr.size());
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int fall;
    m_ready = 1'b1;
    send_cmd(10'h3FE, 11'd4);
    wait_idle(50, ok, fall);
    checks++;
    if (!ok || burst_pops != 4 || last_seen != 1 || exp_addr.size() != 0 || exp_word.size() != 0) begin
      errors++;
      $display("FAIL wrap got ok=%b pops=%0d lasts=%0d left=%0d required 1 4 1 0",
               ok, burst_pops, last_seen, exp_word.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [3:0] pat;
    pat = 4'b1001;
    ok = 1'b0;
    send_cmd(10'h040, 11'd8);
    for (int k = 0; k < 200; k++) begin
      m_ready = pat[k % 4];
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    m_ready = 1'b1;
    checks++;
    if (!ok || burst_pops != 8 || last_seen != 1 || exp_word.size() != 0) begin
      errors++;
      $display("FAIL backpressure got ok=%b pops=%0d lasts=%0d left=%0d required 1 8 1 0",
               ok, burst_pops, last_seen, exp_word.size());
    end
  endtask

  task automatic test_zero_len();
    int en0;
    int drops;
    m_ready = 1'b1;
    en0 = en_seen;
    drops = 0;
    send_cmd(10'h055, 11'd0);
    for (int k = 0; k < 5; k++) begin
      if (cmd_ready !== 1'b1 || busy !== 1'b0) drops++;
      tick();
    end
    checks++;
    if (en_seen != en0 || valid_seen != 0) begin
      errors++;
      $display("FAIL zero_len_activity got issues=%0d valids=%0d required 0 0", en_seen - en0, valid_seen);
    end
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL zero_len_ready got drops=%0d required=0", drops);
    end
  endtask

  task automatic test_max_len();
    bit ok;
    int fall;
    m_ready = 1'b1;
    send_cmd(10'h000, 11'd1024);
    wait_idle(1200, ok, fall);
    checks++;
    if (!ok || burst_pops != 1024 || last_seen != 1 || exp_word.size() != 0) begin
      errors++;
      $display("FAIL max_len got ok=%b pops=%0d lasts=%0d left=%0d required 1 1024 1 0",
               ok, burst_pops, last_seen, exp_word.size());
    end
    checks++;
    if (last_pop_cyc - first_pop_cyc != 1023) begin
      errors++;
      $display("FAIL max_len_rate got span=%0d required=1023", last_pop_cyc - first_pop_cyc);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int fall;
    m_ready = 1'b1;
    ok = 1'b0;
    send_cmd(10'h100, 11'd16);
    for (int k = 0; k < 50; k++) begin
      if (burst_pops >= 2) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_reach got pops=%0d required>=2", burst_pops); end
    rst = 1'b1;
    tick();
    checks++;
    if ({cmd_ready, ram_en, ram_addr, m_valid, m_data, m_last, busy} !== {1'b1, 1'b0, 10'd0, 1'b0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_state got rdy=%b en=%b addr=%h v=%b d=%h l=%b busy=%b required 1 0 000 0 0 0 0",
               cmd_ready, ram_en, ram_addr, m_valid, m_data, m_last, busy);
    end
    rst = 1'b0;
    exp_addr.delete();
    exp_word.delete();
    tick();
    send_cmd(10'h200, 11'd2);
    wait_idle(50, ok, fall);
    checks++;
    if (!ok || burst_pops != 2 || last_seen != 1 || exp_word.size() != 0) begin
      errors++;
      $display("FAIL midrst_after got ok=%b pops=%0d lasts=%0d left=%0d required 1 2 1 0",
               ok, burst_pops, last_seen, exp_word.size());
    end
  endtask

`ifdef RAM_STREAM_READER_ABORT_EN
  task automatic test_abort();
    bit ok;
    int fall;
    m_ready = 1'b1;
    ok = 1'b0;
    send_cmd(10'h020, 11'd10);
    for (int k = 0; k < 50; k++) begin
      if (burst_pops >= 4) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_reach got pops=%0d required>=4", burst_pops); end
    abort = 1'b1;
    #1;
    checks++;
    if (ram_en !== 1'b0) begin errors++; $display("FAIL abort_ram_en got=%b required=0", ram_en); end
    tick();
    abort = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got v=%b rdy=%b busy=%b required 0 1 0", m_valid, cmd_ready, busy);
    end
    exp_addr.delete();
    exp_word.delete();
    valid_seen = 0;
    repeat (4) tick();
    checks++;
    if (valid_seen != 0 || last_seen != 0) begin
      errors++;
      $display("FAIL abort_quiet got valids=%0d lasts=%0d required 0 0", valid_seen, last_seen);
    end
    send_cmd(10'h030, 11'd3);
    wait_idle(50, ok, fall);
    checks++;
    if (!ok || burst_pops != 3 || last_seen != 1 || exp_word.size() != 0) begin
      errors++;
      $display("FAIL abort_after got ok=%b pops=%0d lasts=%0d left=%0d required 1 3 1 0",
               ok, burst_pops, last_seen, exp_word.size());
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    #1;
    test_reset();
    test_single_burst();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_max_len();
    test_reset_mid_burst();
`ifdef RAM_STREAM_READER_ABORT_EN
    test_abort();
`endif
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
